// File: rtl/genius_pkg.sv
// Shared types and helpers for the parametrised memory-game engine (genius_jogo_param).
package genius_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA      = 4'd2,
    APAGA       = 4'd3,
    ESPERA      = 4'd4,
    COMPARA     = 4'd5,
    PROX_JOGADA = 4'd6,
    PROX_RODADA = 4'd7,
    FIM_ACERTO  = 4'd8,
    FIM_ERRO    = 4'd9
  } estado_t;

  localparam int          LFSR_W     = 16;
  localparam int          MAX_BOTOES = 16;
  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // One-hot of the low 'bits' bits of the LFSR state (bits <= 4).
  function automatic logic [MAX_BOTOES-1:0] decode_one_hot(input logic [LFSR_W-1:0] s,
                                                           input int unsigned bits);
    logic [3:0] idx;
    idx = s[3:0] & 4'((1 << bits) - 1);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/genius_jogo_param_if.sv
// Player/board-side signal bundle of genius_jogo_param: buttons and start in, LEDs, result flags and debug out.
interface genius_jogo_param_if #(
  parameter int NUM_BOTOES = 4
);
  logic                  jogar;
  logic [NUM_BOTOES-1:0] botoes;
  logic [NUM_BOTOES-1:0] leds;
  logic                  pronto;
  logic                  ganhou;
  logic                  perdeu;
  logic                  timeout;
  logic [3:0]            db_estado;
  logic [4:0]            db_rodada;
  logic [4:0]            db_jogada;
  logic [NUM_BOTOES-1:0] db_memoria;

  modport master (
    output jogar, botoes,
    input  leds, pronto, ganhou, perdeu, timeout,
    input  db_estado, db_rodada, db_jogada, db_memoria
  );

  modport slave (
    input  jogar, botoes,
    output leds, pronto, ganhou, perdeu, timeout,
    output db_estado, db_rodada, db_jogada, db_memoria
  );
endinterface

// File: rtl/genius_lfsr.sv
// Seedable, step-enabled 16-bit Fibonacci LFSR feeding the game sequence generator.
module genius_lfsr
  import genius_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/genius_jogo_param.sv
// Memory-game engine: fills a pseudo-random sequence, shows growing prefixes, checks presses.
// Optional idle timeout in ESPERA is compiled in when GENIUS_TIMEOUT_EN is defined.
module genius_jogo_param
  import genius_pkg::*;
#(
  parameter int          NUM_BOTOES     = 4,
  parameter int          MAX_RODADAS    = 16,
  parameter int          LED_CICLOS     = 50,
  parameter int          TIMEOUT_CICLOS = 5000,
  parameter logic [15:0] SEMENTE        = 16'hACE1
) (
  input  logic               clock,
  input  logic               reset,
  genius_jogo_param_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_BOTOES);
  localparam int RW    = $clog2(MAX_RODADAS);
  localparam int LW    = $clog2(LED_CICLOS + 1);

  if (NUM_BOTOES < 2 || NUM_BOTOES > MAX_BOTOES || (NUM_BOTOES & (NUM_BOTOES - 1)) != 0) begin : g_bad_botoes
    $error("NUM_BOTOES must be a power of two in 2..16");
  end
  if (MAX_RODADAS < 2 || MAX_RODADAS > 32) begin : g_bad_rodadas
    $error("MAX_RODADAS must be in 2..32");
  end
  if (LED_CICLOS < 1 || TIMEOUT_CICLOS < 1) begin : g_bad_ciclos
    $error("LED_CICLOS and TIMEOUT_CICLOS must be at least 1");
  end

  estado_t               estado;
  logic [RW-1:0]         rodada;
  logic [RW-1:0]         jogada;
  logic [RW-1:0]         fill_idx;
  logic [LW-1:0]         led_cnt;
  logic [NUM_BOTOES-1:0] mem [MAX_RODADAS];
  logic [NUM_BOTOES-1:0] hist;
  logic [NUM_BOTOES-1:0] press_val;
  logic                  press_q;
  logic [NUM_BOTOES-1:0] latched;
  logic [NUM_BOTOES-1:0] leds_q;
  logic                  pronto_q;
  logic                  ganhou_q;
  logic                  perdeu_q;
  logic [LFSR_W-1:0]     lfsr_state;
  logic                  lfsr_step;
  logic [NUM_BOTOES-1:0] elem;

`ifdef GENIUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  logic [TW-1:0] idle_cnt;
  logic          timeout_q;
`endif

  assign lfsr_step = (estado == PREPARA);
  assign elem      = NUM_BOTOES'(decode_one_hot(lfsr_state, IDX_W));

  genius_lfsr #(.SEED(SEMENTE)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // A press is a rising edge of "any button"; only counted while waiting for the player,
  // so buttons held from the display phase never register once ESPERA is reached.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist      <= '0;
      press_q   <= 1'b0;
      press_val <= '0;
    end else begin
      hist      <= bus.botoes;
      press_val <= bus.botoes;
      press_q   <= (estado == ESPERA) && (|bus.botoes) && !(|hist);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      rodada   <= '0;
      jogada   <= '0;
      fill_idx <= '0;
      led_cnt  <= '0;
      latched  <= '0;
      leds_q   <= '0;
      pronto_q <= 1'b0;
      ganhou_q <= 1'b0;
      perdeu_q <= 1'b0;
      // NOTE: the sequence store is reset too, because db_memoria reads it and must be 0 after reset.
      for (int i = 0; i < MAX_RODADAS; i++) mem[i] <= '0;
`ifdef GENIUS_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (estado)
        INICIAL, FIM_ACERTO, FIM_ERRO: begin
          if (bus.jogar) begin
            estado   <= PREPARA;
            fill_idx <= '0;
            rodada   <= '0;
            jogada   <= '0;
            pronto_q <= 1'b0;
            ganhou_q <= 1'b0;
            perdeu_q <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end

        PREPARA: begin
          mem[fill_idx] <= elem;
          if (fill_idx == RW'(MAX_RODADAS - 1)) begin
            estado  <= MOSTRA;
            led_cnt <= '0;
            leds_q  <= mem[0];
          end else begin
            fill_idx <= fill_idx + 1'b1;
          end
        end

        MOSTRA: begin
          if (led_cnt == LW'(LED_CICLOS - 1)) begin
            estado  <= APAGA;
            led_cnt <= '0;
            leds_q  <= '0;
          end else begin
            led_cnt <= led_cnt + 1'b1;
          end
        end

        APAGA: begin
          if (led_cnt == LW'(LED_CICLOS - 1)) begin
            led_cnt <= '0;
            if (jogada < rodada) begin
              jogada <= jogada + 1'b1;
              leds_q <= mem[jogada + 1'b1];
              estado <= MOSTRA;
            end else begin
              jogada <= '0;
              estado <= ESPERA;
`ifdef GENIUS_TIMEOUT_EN
              idle_cnt <= '0;
`endif
            end
          end else begin
            led_cnt <= led_cnt + 1'b1;
          end
        end

        ESPERA: begin
          if (press_q) begin
            latched <= press_val;
            estado  <= COMPARA;
          end
`ifdef GENIUS_TIMEOUT_EN
          // A press in the expiry cycle takes priority over the timeout.
          else if (idle_cnt == TW'(TIMEOUT_CICLOS - 1)) begin
            estado    <= FIM_ERRO;
            pronto_q  <= 1'b1;
            perdeu_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end

        COMPARA: begin
          if (latched != mem[jogada]) begin
            estado   <= FIM_ERRO;
            pronto_q <= 1'b1;
            perdeu_q <= 1'b1;
          end else if (jogada != rodada) begin
            estado <= PROX_JOGADA;
          end else if (rodada == RW'(MAX_RODADAS - 1)) begin
            estado   <= FIM_ACERTO;
            pronto_q <= 1'b1;
            ganhou_q <= 1'b1;
          end else begin
            estado <= PROX_RODADA;
          end
        end

        PROX_JOGADA: begin
          jogada <= jogada + 1'b1;
          estado <= ESPERA;
`ifdef GENIUS_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end

        PROX_RODADA: begin
          rodada  <= rodada + 1'b1;
          jogada  <= '0;
          led_cnt <= '0;
          leds_q  <= mem[0];
          estado  <= MOSTRA;
        end

        default: estado <= INICIAL;
      endcase
    end
  end

  assign bus.leds       = leds_q;
  assign bus.pronto     = pronto_q;
  assign bus.ganhou     = ganhou_q;
  assign bus.perdeu     = perdeu_q;
  assign bus.db_estado  = estado;
  assign bus.db_rodada  = 5'(rodada);
  assign bus.db_jogada  = 5'(jogada);
  assign bus.db_memoria = mem[jogada];
`ifdef GENIUS_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_genius_jogo_param.sv
// Directed self-checking bench for genius_jogo_param with an LED-display scoreboard and an LFSR reference model.
module tb_genius_jogo_param;

  localparam int          NB      = 4;
  localparam int          ROUNDS  = 16;
  localparam int          LED     = 50;
  localparam int          TMO     = 5000;
  localparam logic [15:0] SEED    = 16'hACE1;

  localparam logic [3:0] S_INICIAL  = 4'd0;
  localparam logic [3:0] S_PREPARA  = 4'd1;
  localparam logic [3:0] S_MOSTRA   = 4'd2;
  localparam logic [3:0] S_APAGA    = 4'd3;
  localparam logic [3:0] S_ESPERA   = 4'd4;
  localparam logic [3:0] S_COMPARA  = 4'd5;
  localparam logic [3:0] S_FIM_OK   = 4'd8;
  localparam logic [3:0] S_FIM_ERRO = 4'd9;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  genius_jogo_param_if #(.NUM_BOTOES(NB)) bus ();

  genius_jogo_param #(
    .NUM_BOTOES     (NB),
    .MAX_RODADAS    (ROUNDS),
    .LED_CICLOS     (LED),
    .TIMEOUT_CICLOS (TMO),
    .SEMENTE        (SEED)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_lfsr;
  logic [3:0]  seq [ROUNDS];
  logic [3:0]  exp_q [$];
  logic [3:0]  wrong;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sequence: the engine steps its LFSR exactly ROUNDS times per game fill.
  task automatic new_sequence();
    for (int k = 0; k < ROUNDS; k++) begin
      seq[k]     = 4'b0001 << model_lfsr[1:0];
      model_lfsr = {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
    end
  endtask

  task automatic wait_state(input logic [3:0] code, input int budget, input string tag);
    int k = 0;
    while (bus.db_estado !== code && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, bus.db_estado, code);
  endtask

  task automatic press(input logic [3:0] v);
    bus.botoes = v;
    @(negedge clock);
    bus.botoes = '0;
    @(negedge clock);
  endtask

  task automatic start_game();
    new_sequence();
    bus.jogar = 1'b1;
    @(negedge clock);
    check("prepara_entry", bus.db_estado, S_PREPARA);
    check("prepara_pronto", bus.pronto, 0);
    check("prepara_ganhou", bus.ganhou, 0);
    check("prepara_perdeu", bus.perdeu, 0);
    check("prepara_timeout", bus.timeout, 0);
    check("prepara_rodada", bus.db_rodada, 0);
    repeat (4) @(negedge clock);
    bus.jogar = 1'b0;
    repeat (12) @(negedge clock);
    check("mostra_latency", bus.db_estado, S_MOSTRA);
    check("mostra_jogada0", bus.db_jogada, 0);
  endtask

  // Shows round r through the scoreboard, then plays the first n_ok entries correctly.
  task automatic play_round(input int r, input int n_ok);
    int         cyc;
    logic [3:0] prev_led;
    logic [3:0] exp;
    wait_state(S_MOSTRA, 40, "mostra_entry");
    check("rodada_idx", bus.db_rodada, r);
    for (int j = 0; j <= r; j++) exp_q.push_back(seq[j]);
    cyc      = 0;
    prev_led = '0;
    while (bus.db_estado !== S_ESPERA && cyc < 2 * LED * (r + 1) + 20) begin
      if (bus.leds !== 4'b0000 && prev_led === 4'b0000) begin
        if (exp_q.size() == 0) check("leds_extra", bus.leds, 0);
        else begin
          exp = exp_q.pop_front();
          check("leds", bus.leds, exp);
        end
      end
      prev_led = bus.leds;
      @(negedge clock);
      cyc++;
    end
    check("disp_len", cyc, 2 * LED * (r + 1));
    check("leds_missing", exp_q.size(), 0);
    exp_q.delete();
    for (int j = 0; j < n_ok; j++) begin
      wait_state(S_ESPERA, 20, "espera");
      check("memoria", bus.db_memoria, seq[j]);
      press(seq[j]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.jogar  = 1'b0;
    bus.botoes = '0;
    model_lfsr = SEED;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("rst_estado", bus.db_estado, S_INICIAL);
    check("rst_leds", bus.leds, 0);
    check("rst_pronto", bus.pronto, 0);
    check("rst_ganhou", bus.ganhou, 0);
    check("rst_perdeu", bus.perdeu, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_rodada", bus.db_rodada, 0);
    check("rst_jogada", bus.db_jogada, 0);
    check("rst_memoria", bus.db_memoria, 0);

    // Game 1: full win.
    start_game();
    for (int r = 0; r < ROUNDS; r++) play_round(r, r + 1);
    wait_state(S_FIM_OK, 10, "win_state");
    check("win_ganhou", bus.ganhou, 1);
    check("win_pronto", bus.pronto, 1);
    check("win_perdeu", bus.perdeu, 0);
    check("win_rodada", bus.db_rodada, ROUNDS - 1);

    // Game 2 (LFSR not reseeded): wrong press at round 4, play 2.
    start_game();
    for (int r = 0; r < 4; r++) play_round(r, r + 1);
    play_round(4, 2);
    wait_state(S_ESPERA, 20, "loss_espera");
    wrong      = {seq[2][2:0], seq[2][3]};
    bus.botoes = wrong;
    @(negedge clock);
    bus.botoes = '0;
    @(negedge clock);
    check("loss_compara_latency", bus.db_estado, S_COMPARA);
    @(negedge clock);
    check("loss_state", bus.db_estado, S_FIM_ERRO);
    check("loss_perdeu", bus.perdeu, 1);
    check("loss_pronto", bus.pronto, 1);
    check("loss_ganhou", bus.ganhou, 0);
    check("loss_timeout", bus.timeout, 0);
    check("loss_rodada", bus.db_rodada, 4);
    check("loss_jogada", bus.db_jogada, 2);

    // Game 3: idle in ESPERA.
    start_game();
    play_round(0, 0);
`ifdef GENIUS_TIMEOUT_EN
    repeat (TMO - 1) @(negedge clock);
    check("tmo_not_yet", bus.db_estado, S_ESPERA);
    @(negedge clock);
    check("tmo_state", bus.db_estado, S_FIM_ERRO);
    check("tmo_flag", bus.timeout, 1);
    check("tmo_perdeu", bus.perdeu, 1);
    start_game();
    play_round(0, 0);
`else
    repeat (2 * TMO) @(negedge clock);
    check("no_tmo_state", bus.db_estado, S_ESPERA);
    check("no_tmo_flag", bus.timeout, 0);
`endif
    // Two buttons at once, one of them the expected one.
    press(seq[0] | {seq[0][2:0], seq[0][3]});
    wait_state(S_FIM_ERRO, 10, "multi_state");
    check("multi_perdeu", bus.perdeu, 1);
    check("multi_timeout", bus.timeout, 0);

    // Button held from APAGA into ESPERA must not count.
    start_game();
    wait_state(S_APAGA, 3 * LED, "held_apaga");
    bus.botoes = seq[0];
    wait_state(S_ESPERA, 3 * LED, "held_espera");
    repeat (20) @(negedge clock);
    check("held_no_compara", bus.db_estado, S_ESPERA);
    bus.botoes = '0;
    repeat (2) @(negedge clock);
    press(seq[0]);
    wait_state(S_MOSTRA, 10, "held_next_round");
    check("held_rodada", bus.db_rodada, 1);

    // Reset in the middle of a display.
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_estado", bus.db_estado, S_INICIAL);
    check("midrst_leds", bus.leds, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_rodada", bus.db_rodada, 0);
    check("midrst_memoria", bus.db_memoria, 0);

    // After reset the LFSR restarts from the seed: first game sequence again.
    model_lfsr = SEED;
    start_game();
    play_round(0, 1);
    wait_state(S_MOSTRA, 10, "reseed_round1");
    check("reseed_rodada", bus.db_rodada, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/genius_jogo_param.md
# genius_jogo_param

Parametrised successor of the memory-game datapath/control pair: a self-contained game engine with configurable button count, sequence depth, LED display time and play timeout. It generates a pseudo-random sequence, shows a growing prefix on the LEDs each round, checks the player's presses against it, and reports win, loss or timeout. It sits between the debounced button inputs and the board LEDs/HEX debug decoders, replacing the separate fluxo de dados plus unidade de controle.

## Interface
Parameters:
- NUM_BOTOES, 4: buttons/LEDs; power of two, 2..16
- MAX_RODADAS, 16: sequence depth = number of rounds; 2..32
- LED_CICLOS, 50: cycles each LED stays lit, and length of the dark gap after it
- TIMEOUT_CICLOS, 5000: max idle cycles in ESPERA before loss
- SEMENTE, 16'hACE1: non-zero LFSR seed loaded on reset

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- jogar  in  1  level; starts a game from INICIAL or a FIM state
- botoes  in  NUM_BOTOES  button levels, 1 = pressed
- leds  out  NUM_BOTOES  one-hot during display, else 0
- pronto  out  1  high in FIM_ACERTO/FIM_ERRO
- ganhou  out  1  high in FIM_ACERTO
- perdeu  out  1  high in FIM_ERRO
- timeout  out  1  high in FIM_ERRO when the cause was timeout
- db_estado  out  4  state code
- db_rodada  out  5  current round index, 0-based
- db_jogada  out  5  current play index within round
- db_memoria  out  NUM_BOTOES  one-hot expected element at db_jogada

## Operation
- Sequence element k = one-hot of 16-bit Fibonacci LFSR (taps 16,14,13,11) low log2(NUM_BOTOES) bits; stored in an MAX_RODADAS-entry register array.
- LFSR loads SEMENTE on reset only; steps once per fill cycle; not reseeded on replay, so second game after reset differs from first.
- States/codes: INICIAL 0, PREPARA 1, MOSTRA 2, APAGA 3, ESPERA 4, COMPARA 5, PROX_JOGADA 6, PROX_RODADA 7, FIM_ACERTO 8, FIM_ERRO 9.
- INICIAL: outputs 0; jogar=1 -> PREPARA.
- PREPARA: writes entry i each cycle, i = 0..MAX_RODADAS-1, then MOSTRA with rodada=0, jogada=0.
- MOSTRA: leds = entry[jogada] for LED_CICLOS cycles -> APAGA (leds=0, LED_CICLOS cycles). Then if jogada<rodada: jogada+1, MOSTRA; else jogada=0, ESPERA.
- Press = botoes nonzero while previous-cycle botoes was all-zero (registered edge detector). Held or additional buttons are not new presses until all released.
- ESPERA: press -> latch botoes, COMPARA. Idle counter counts cycles in ESPERA; reset on entry.
- COMPARA: latched value == entry[jogada] (exact one-hot match; multi-button press is an error). Mismatch -> FIM_ERRO, timeout=0. Match and jogada<rodada -> PROX_JOGADA (jogada+1) -> ESPERA. Match and jogada==rodada: if rodada==MAX_RODADAS-1 -> FIM_ACERTO, else PROX_RODADA (rodada+1, jogada=0) -> MOSTRA.
- FIM states hold until jogar=1 -> PREPARA (flags cleared on exit).
- jogar ignored in all other states.

## Timing
- Reset: state INICIAL, all outputs 0, counters 0, LFSR=SEMENTE, edge-detector history = all-zero.
- jogar sampled high at edge n -> PREPARA at n+1; MOSTRA at n+1+MAX_RODADAS.
- Round r display lasts exactly 2*LED_CICLOS*(r+1) cycles.
- Press visible at edge n -> edge detector registered n+1 -> COMPARA at n+2 -> next state n+3.
- Timeout: no press for TIMEOUT_CICLOS consecutive ESPERA cycles -> FIM_ERRO, timeout=1, on the following edge. Press in the same cycle as expiry wins (goes to COMPARA).
- Presses during MOSTRA/APAGA are ignored but update edge history (press held into ESPERA does not count).
- Reset mid-game aborts immediately to reset values.

## Configuration
- GENIUS_TIMEOUT_EN defined: idle counter and timeout path compiled in as above.
- Undefined: no counter; ESPERA waits indefinitely; timeout tied 0; TIMEOUT_CICLOS unused.

## Structure
- Package genius_pkg: state enum with codes above, LFSR taps/width constant, one-hot decode function.
- One sub-module genius_lfsr (seedable step-enabled 16-bit LFSR); everything else in the top.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, db_estado=0.
- Defaults, jogar 5 cycles, bench plays db_memoria for every play of all 16 rounds -> ganhou=1, pronto=1, perdeu=0, db_rodada=15.
- Round 4 (0-based), play 2 pressed as wrong one-hot -> perdeu=1, timeout=0, db_rodada=4, db_jogada=2.
- Round 0, no press for 5000 cycles -> FIM_ERRO, timeout=1; with macro undefined -> stays in ESPERA after 10000 cycles.
- Two buttons pressed together matching expected bit -> perdeu=1; button held from APAGA into ESPERA -> no COMPARA until release and re-press.
- After FIM, jogar again -> PREPARA, flags cleared, sequence differs from first game; reset mid-MOSTRA -> INICIAL next cycle, leds=0.
